conv_row_scheduler: RTL
=======================

Name: conv_row_scheduler

Overview:
- Sequences the shared convolution engine over a multi-row frame.
- Ping-pong row buffers let reception of row k+1 overlap computation of row k.
- For each row, scans the engine's results for the signed maximum and its index.
- Emits one result per row on a valid/ready output; sits between the byte receiver and the result transmitter.

Parameters:
- PIX_W, 8, bits per pixel.
- ROW_LEN, 32, pixels per row.
- RES_W, 18, signed result width from the engine.
- NUM_RES, 30, results per row (ROW_LEN-2).
- NUM_ROWS, 32, rows per frame.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a frame; sampled only in IDLE.
- rx_data  in  PIX_W  pixel byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  scheduler can accept a byte.
- eng_start  out  1  one-cycle engine start pulse.
- eng_pixels  out  ROW_LEN*PIX_W  row to engine; pixel i at [i*PIX_W +: PIX_W].
- eng_done  in  1  engine finished; eng_result stable until next eng_start.
- eng_result  in  NUM_RES*RES_W  signed results; result i at [i*RES_W +: RES_W].
- tx_data  out  RES_W  row maximum (signed).
- tx_idx  out  5  index of the maximum.
- tx_row  out  5  row number, 0-based.
- tx_valid  out  1  output valid.
- tx_ready  in  1  consumer accepts.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last row's output is accepted.

Behaviour:
- Reset: all outputs 0; both buffers marked empty; all counters 0; control in IDLE, compute in C_IDLE.
- Top control:
  - IDLE -> RUN on start. busy=1 in RUN.
  - start while in RUN is ignored.
- Receive side:
  - rx_ready = RUN && buffer[wr_buf] empty && rows_rx < NUM_ROWS (combinational from registered state).
  - A byte is accepted when rx_valid && rx_ready; it is written to buffer[wr_buf][fill_cnt].
  - On the byte with fill_cnt==ROW_LEN-1: mark the buffer full, toggle wr_buf, clear fill_cnt, increment rows_rx.
  - rx_valid gaps are allowed; no data is lost.
- Compute FSM (C_IDLE, C_WAIT, C_MAX, C_OUT):
  - C_IDLE: if RUN and buffer[rd_buf] is full, assert eng_start for one cycle and go to C_WAIT. If the last byte of a row is accepted in cycle T with compute idle, eng_start is high in T+1.
  - eng_pixels always reflects buffer[rd_buf]. It is held stable from eng_start through eng_done.
  - C_WAIT: on eng_done (cycle D): max<=result[0], idx<=0, scan counter<=1, mark buffer[rd_buf] empty, toggle rd_buf, go to C_MAX. The freed buffer is visible to rx_ready at D+1.
  - C_MAX: one result per cycle for counter 1..NUM_RES-1, i.e. cycles D+1..D+29. Signed compare; strictly greater replaces max and idx, so ties keep the lowest index. After counter NUM_RES-1, go to C_OUT.
  - C_OUT: tx_valid=1 from D+30. tx_data, tx_idx and tx_row are held stable until tx_valid && tx_ready.
  - On acceptance: rows_done++. If rows_done reaches NUM_ROWS, pulse frame_done, return to IDLE and clear counters. Otherwise go to C_IDLE.
- Boundary conditions:
  - eng_done outside C_WAIT is ignored.
  - Both buffers full plus tx stalled: rx_ready=0 until a buffer frees.
  - Buffer release and fill completion in the same cycle touch different buffers; both take effect.
  - rows_rx == NUM_ROWS: rx_ready=0 for the rest of the frame.
  - rst mid-frame: immediate return to reset state; partial rows are discarded, no tx_valid, no frame_done.

Test Plan:
- NUM_ROWS=2, engine model returns result i = i-15 for both rows:
  - tx row0 has tx_data=14, tx_idx=29; tx row1 has the same values with tx_row=1.
  - frame_done pulses once, after the second handshake.
- All results = -5: tx_data=18'h3FFFB, tx_idx=0 (tie keeps first). Results with max 100 at indices 3 and 17: tx_idx=3.
- Latency: last byte accepted at T -> eng_start at T+1. Engine done at D -> tx_valid first high at D+30.
- tx_ready held low 200 cycles, rx_valid constant:
  - exactly 64 bytes accepted, then rx_ready=0 until the row-0 eng_done frees a buffer;
  - reception resumes at 96 bytes max before stalling again;
  - tx outputs stay stable throughout the stall.
- rx_valid toggling every other cycle: row data is received correctly; eng_pixels matches the sent bytes in order.
- Reset and start interactions:
  - rst asserted mid-C_MAX: all outputs 0 next cycle; no tx_valid afterward.
  - A new start then runs a clean frame.
  - start pulsed during RUN changes nothing.

Source files
------------

// File: rtl/conv_row_scheduler.sv
// Row scheduler for the shared convolution engine: ping-pong row buffers fed by the
// byte receiver, engine sequencing, and a signed-max scan per row toward the transmitter.
module conv_row_scheduler #(
    parameter int unsigned PIX_W    = 8,
    parameter int unsigned ROW_LEN  = 32,
    parameter int unsigned RES_W    = 18,
    parameter int unsigned NUM_RES  = 30,
    parameter int unsigned NUM_ROWS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [PIX_W-1:0]           rx_data,
    input  logic                       rx_valid,
    output logic                       rx_ready,
    output logic                       eng_start,
    output logic [ROW_LEN*PIX_W-1:0]   eng_pixels,
    input  logic                       eng_done,
    input  logic [NUM_RES*RES_W-1:0]   eng_result,
    output logic [RES_W-1:0]           tx_data,
    output logic [4:0]                 tx_idx,
    output logic [4:0]                 tx_row,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       frame_done
);
    localparam int unsigned ROW_BITS = ROW_LEN * PIX_W;
    localparam int unsigned FILL_W   = $clog2(ROW_LEN);
    localparam int unsigned ROWS_W   = $clog2(NUM_ROWS + 1);
    localparam int unsigned SCAN_W   = $clog2(NUM_RES);

    typedef enum logic {IDLE, RUN} ctl_state_t;
    typedef enum logic [1:0] {C_IDLE, C_WAIT, C_MAX, C_OUT} cmp_state_t;

    ctl_state_t ctl_q, ctl_d;
    cmp_state_t cmp_q, cmp_d;

    logic [ROW_BITS-1:0] row_buf [2];
    logic [1:0]          buf_full;
    logic                wr_buf;
    logic                rd_buf;
    logic [FILL_W-1:0]   fill_cnt;
    logic [ROWS_W-1:0]   rows_rx;
    logic [ROWS_W-1:0]   rows_done;
    logic [SCAN_W-1:0]   scan_cnt;

    logic             run;
    logic             rx_fire;
    logic             row_last;
    logic             tx_fire;
    logic             frame_last;
    logic [RES_W-1:0] cur_res;

    assign run        = (ctl_q == RUN);
    assign busy       = run;
    assign rx_ready   = run && !buf_full[wr_buf] && (rows_rx < ROWS_W'(NUM_ROWS));
    assign rx_fire    = rx_valid && rx_ready;
    assign row_last   = (fill_cnt == FILL_W'(ROW_LEN - 1));
    assign tx_fire    = tx_valid && tx_ready;
    assign frame_last = (rows_done == ROWS_W'(NUM_ROWS - 1));
    assign eng_pixels = row_buf[rd_buf];
    assign cur_res    = eng_result[scan_cnt*RES_W +: RES_W];

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_q <= IDLE;
            cmp_q <= C_IDLE;
        end else begin
            ctl_q <= ctl_d;
            cmp_q <= cmp_d;
        end
    end

    // Frame-level control: leaves RUN once the final row result is accepted
    always_comb begin
        ctl_d = ctl_q;
        unique case (ctl_q)
            IDLE:    if (start) ctl_d = RUN;
            RUN:     if (tx_fire && frame_last) ctl_d = IDLE;
            default: ctl_d = IDLE;
        endcase
    end

    // Compute sequencing: launch engine, scan results, present row result
    always_comb begin
        cmp_d     = cmp_q;
        eng_start = 1'b0;
        tx_valid  = 1'b0;
        unique case (cmp_q)
            C_IDLE: begin
                if (run && buf_full[rd_buf]) begin
                    eng_start = 1'b1;
                    cmp_d     = C_WAIT;
                end
            end
            C_WAIT:  if (eng_done) cmp_d = C_MAX;
            C_MAX:   if (scan_cnt == SCAN_W'(NUM_RES - 1)) cmp_d = C_OUT;
            C_OUT: begin
                tx_valid = 1'b1;
                if (tx_ready) cmp_d = C_IDLE;
            end
            default: cmp_d = C_IDLE;
        endcase
    end

    // Row buffers, counters and the running maximum (held in tx_data/tx_idx)
    always_ff @(posedge clk) begin
        if (rst) begin
            row_buf[0] <= '0;
            row_buf[1] <= '0;
            buf_full   <= '0;
            wr_buf     <= 1'b0;
            rd_buf     <= 1'b0;
            fill_cnt   <= '0;
            rows_rx    <= '0;
            rows_done  <= '0;
            scan_cnt   <= '0;
            tx_data    <= '0;
            tx_idx     <= '0;
            tx_row     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (rx_fire) begin
                row_buf[wr_buf][fill_cnt*PIX_W +: PIX_W] <= rx_data;
                if (row_last) begin
                    buf_full[wr_buf] <= 1'b1;
                    wr_buf           <= ~wr_buf;
                    fill_cnt         <= '0;
                    rows_rx          <= rows_rx + 1'b1;
                end else begin
                    fill_cnt <= fill_cnt + 1'b1;
                end
            end

            // Release is always on rd_buf, which cannot be the buffer being filled
            if (cmp_q == C_WAIT && eng_done) begin
                tx_data          <= eng_result[RES_W-1:0];
                tx_idx           <= '0;
                tx_row           <= 5'(rows_done);
                scan_cnt         <= SCAN_W'(1);
                buf_full[rd_buf] <= 1'b0;
                rd_buf           <= ~rd_buf;
            end

            if (cmp_q == C_MAX) begin
                if ($signed(cur_res) > $signed(tx_data)) begin
                    tx_data <= cur_res;
                    tx_idx  <= 5'(scan_cnt);
                end
                scan_cnt <= scan_cnt + 1'b1;
            end

            if (tx_fire) begin
                if (frame_last) begin
                    frame_done <= 1'b1;
                    rows_done  <= '0;
                    rows_rx    <= '0;
                    fill_cnt   <= '0;
                    wr_buf     <= 1'b0;
                    rd_buf     <= 1'b0;
                    buf_full   <= '0;
                end else begin
                    rows_done <= rows_done + 1'b1;
                end
            end
        end
    end
endmodule
